// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared cache types, AXI encodings and write-back FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [7:0]  uint8_t;

    localparam logic [1:0] c_AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wb_state_t;

    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage
`default_nettype wire

// File: rtl/victim_wb_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : victim_wb_engine_if
// Description : AXI write channel (AW/W/B) bundle between engine and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface victim_wb_engine_if #(
    parameter int DATA_WIDTH = 32
);
    import cache_pkg::*;

    phys_t                   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bvalid, bresp
    );

endinterface
`default_nettype wire

// File: rtl/victim_wb_engine.sv
`default_nettype none
// ============================================================================
// Module      : victim_wb_engine
// Description : Pops dirty victim lines and writes each as one AXI INCR burst.
//               VICTIM_WB_ENGINE_AW_W_PARALLEL_EN issues AW and W concurrently.
// Revision    : 1.0 - initial release
// ============================================================================
module victim_wb_engine
    import cache_pkg::*;
#(
    parameter  int LINE_WIDTH  = 256,
    parameter  int DATA_WIDTH  = 32,
    localparam int BEATS       = LINE_WIDTH / DATA_WIDTH,
    localparam int LABEL_WIDTH = 32 - $clog2(LINE_WIDTH / 8)
) (
    input  wire                              clk,
    input  wire                              rst,
    input  wire [LABEL_WIDTH+LINE_WIDTH-1:0] rline,
    input  wire                              empty,
    output logic                             pop,
    output logic                             busy,
    output logic [LABEL_WIDTH-1:0]           busy_label,
    output logic                             err,
    victim_wb_engine_if.master               axi
);

    localparam int               CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int               OFFSET_W    = 32 - LABEL_WIDTH;
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BEATS - 1);

    typedef logic [BEATS-1:0][DATA_WIDTH-1:0] line_t;

    wb_state_t              r_state;
    wb_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [LABEL_WIDTH-1:0] r_label;
    line_t                  r_data;
    logic                   r_err;

    logic w_pop;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_is_last;
    logic w_w_hs;
    logic w_b_hs;

    assign w_is_last = (r_cnt == c_LAST_BEAT);
    assign w_w_hs    = w_wvalid & axi.wready;
    assign w_b_hs    = w_bready & axi.bvalid;

`ifdef VICTIM_WB_ENGINE_AW_W_PARALLEL_EN
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;

    assign w_aw_hs = w_awvalid & axi.awready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gating with rst keeps a line from being popped and then lost.
                if (!empty && !rst) begin
                    w_pop = 1'b1;
`ifdef VICTIM_WB_ENGINE_AW_W_PARALLEL_EN
                    w_state_nxt = DATA;
`else
                    w_state_nxt = ADDR;
`endif
                end
            end
            ADDR: begin
                w_awvalid = 1'b1;
                if (axi.awready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
`ifdef VICTIM_WB_ENGINE_AW_W_PARALLEL_EN
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || axi.awready) &&
                    (r_w_done || (axi.wready && w_is_last))) begin
                    w_state_nxt = RESP;
                end
`else
                w_wvalid = 1'b1;
                if (axi.wready && w_is_last) begin
                    w_state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                w_bready = 1'b1;
                if (axi.bvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_label <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
`ifdef VICTIM_WB_ENGINE_AW_W_PARALLEL_EN
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                {r_label, r_data} <= rline;
            end
            if (w_w_hs) begin
                r_cnt <= w_is_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_b_hs && (axi.bresp != c_AXI_RESP_OKAY)) begin
                r_err <= 1'b1;
            end
`ifdef VICTIM_WB_ENGINE_AW_W_PARALLEL_EN
            if (w_pop) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs && w_is_last) begin
                    r_w_done <= 1'b1;
                end
            end
`endif
        end
    end

    assign pop         = w_pop;
    assign busy        = (r_state != IDLE);
    assign busy_label  = r_label;
    assign err         = r_err;

    assign axi.awaddr  = {r_label, {OFFSET_W{1'b0}}};
    assign axi.awlen   = 4'(BEATS - 1);
    assign axi.awsize  = axi_size(DATA_WIDTH / 8);
    assign axi.awburst = c_AXI_BURST_INCR;
    assign axi.awvalid = w_awvalid;
    assign axi.wdata   = r_data[r_cnt];
    assign axi.wstrb   = '1;
    assign axi.wlast   = w_wvalid & w_is_last;
    assign axi.wvalid  = w_wvalid;
    assign axi.bready  = w_bready;

endmodule
`default_nettype wire
